// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM blocks: state encodings and ratio sizing.
package motor_pkg;

    localparam int unsigned PWM_PERIOD_TICKS = 256;
    localparam int unsigned PWM_RATIO_W      = 8;

    typedef enum logic [1:0] {
        PWM_IDLE     = 2'd0,
        PWM_RUN      = 2'd1,
        PWM_DEADTIME = 2'd2
    } pwm_state_t;

    typedef logic [PWM_RATIO_W-1:0] pwm_ratio_t;

endpackage

// File: rtl/pwm_ratio_driver_if.sv
// Request/acknowledge bus between the angle controller and the PWM ratio driver.
interface pwm_ratio_driver_if;
    import motor_pkg::*;

    logic       pwm_enable;
    logic       pwm_update;
    pwm_ratio_t pwm_ratio;
    logic       pwm_direction;
    logic       pwm_done;

    modport master (
        output pwm_enable,
        output pwm_update,
        output pwm_ratio,
        output pwm_direction,
        input  pwm_done
    );

    modport slave (
        input  pwm_enable,
        input  pwm_update,
        input  pwm_ratio,
        input  pwm_direction,
        output pwm_done
    );

endinterface

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every PRESCALE clocks, restartable by a synchronous clear.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned PRE_W = $clog2(PRESCALE + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    assign tick_c = (pre_cnt == PRE_LAST);

    // Count 0..PRESCALE-1; clear holds the count at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (clear || tick_c) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ratio_driver.sv
// PWM ratio driver: boundary-sampled ratio/direction, dead time on reversal, done pulse per load.
module pwm_ratio_driver
    import motor_pkg::*;
#(
    parameter int unsigned PRESCALE         = 4,
    parameter int unsigned DEADTIME_PERIODS = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    pwm_ratio_driver_if.slave        bus,
    output logic                     pwm_out,
    output logic                     dir_out,
    output pwm_ratio_t               active_ratio
);

    localparam int unsigned DT_W = $clog2(DEADTIME_PERIODS + 1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_PERIODS - 1);
    localparam pwm_ratio_t CNT_LAST = PWM_RATIO_W'(PWM_PERIOD_TICKS - 1);

    pwm_state_t       state;
    pwm_ratio_t       cnt;
    logic [DT_W-1:0]  dt_cnt;
    logic             tick_c;
    logic             clear_c;
    logic             boundary_c;

    // Prescaler is held at zero while idle or being disabled so a new run starts cleanly.
    assign clear_c    = (state == PWM_IDLE) || !bus.pwm_enable;
    assign boundary_c = tick_c && (cnt == CNT_LAST);

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear_c),
        .tick_c  (tick_c)
    );

    // FSM, period counter, active ratio, dead-time counter and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= PWM_IDLE;
            cnt          <= '0;
            dt_cnt       <= '0;
            active_ratio <= '0;
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            bus.pwm_done <= 1'b0;
        end else begin
            bus.pwm_done <= 1'b0;
            if (!bus.pwm_enable) begin
                // Disable wins over any boundary event; dir_out is kept.
                state        <= PWM_IDLE;
                cnt          <= '0;
                dt_cnt       <= '0;
                active_ratio <= '0;
                pwm_out      <= 1'b0;
            end else begin
                case (state)
                    PWM_IDLE: begin
                        cnt          <= '0;
                        dt_cnt       <= '0;
                        active_ratio <= '0;
                        pwm_out      <= 1'b0;
                        state        <= PWM_RUN;
                    end
                    PWM_RUN: begin
                        pwm_out <= (cnt < active_ratio);
                        if (tick_c) begin
                            cnt <= cnt + PWM_RATIO_W'(1);
                        end
                        if (boundary_c && bus.pwm_update) begin
                            if (bus.pwm_direction == dir_out) begin
                                active_ratio <= bus.pwm_ratio;
                                bus.pwm_done <= 1'b1;
                            end else begin
                                state        <= PWM_DEADTIME;
                                dt_cnt       <= '0;
                                active_ratio <= '0;
                            end
                        end
                    end
                    PWM_DEADTIME: begin
                        pwm_out <= 1'b0;
                        if (tick_c) begin
                            cnt <= cnt + PWM_RATIO_W'(1);
                        end
                        if (boundary_c) begin
                            if (dt_cnt == DT_LAST) begin
                                dir_out      <= bus.pwm_direction;
                                active_ratio <= bus.pwm_ratio;
                                bus.pwm_done <= 1'b1;
                                dt_cnt       <= '0;
                                state        <= PWM_RUN;
                            end else begin
                                dt_cnt <= dt_cnt + DT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= PWM_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ratio_driver.sv
// Scoreboarded bench: expected pwm_done events are queued by the stimulus and popped by monitors.
module tb_pwm_ratio_driver;
    import motor_pkg::*;

    typedef struct {
        int cyc;
        int ratio;
        int dir;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rst4_n;
    logic       out1, dir1, out4, dir4;
    pwm_ratio_t ar1, ar4;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q1[$];
    exp_t q4[$];

    pwm_ratio_driver_if if1();
    pwm_ratio_driver_if if4();

    pwm_ratio_driver #(.PRESCALE(1), .DEADTIME_PERIODS(2)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (if1),
        .pwm_out      (out1),
        .dir_out      (dir1),
        .active_ratio (ar1)
    );

    pwm_ratio_driver #(.PRESCALE(4), .DEADTIME_PERIODS(2)) dut4 (
        .clock        (clock),
        .reset_n      (rst4_n),
        .bus          (if4),
        .pwm_out      (out4),
        .dir_out      (dir4),
        .active_ratio (ar4)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push1(input int c, input int r, input int d);
        exp_t e;
        e.cyc = c; e.ratio = r; e.dir = d;
        q1.push_back(e);
    endtask

    task automatic push4(input int c, input int r, input int d);
        exp_t e;
        e.cyc = c; e.ratio = r; e.dir = d;
        q4.push_back(e);
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic count_high(input int n, input bit sel4, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clock);
            hi += sel4 ? int'(out4) : int'(out1);
        end
    endtask

    // Monitor for the PRESCALE=1 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (if1.pwm_done) begin
                if (q1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done1_unexpected: got pulse at cycle %0d, required none", cyc);
                end else begin
                    e = q1.pop_front();
                    check("done1_cycle", cyc, e.cyc);
                    check("done1_ratio", int'(ar1), e.ratio);
                    check("done1_dir", int'(dir1), e.dir);
                end
            end
        end
    end

    // Monitor for the PRESCALE=4 instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (if4.pwm_done) begin
                if (q4.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL done4_unexpected: got pulse at cycle %0d, required none", cyc);
                end else begin
                    e = q4.pop_front();
                    check("done4_cycle", cyc, e.cyc);
                    check("done4_ratio", int'(ar4), e.ratio);
                    check("done4_dir", int'(dir4), e.dir);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int b, c0, c1, c2, h1, h2;
        reset_n = 1'b0;
        rst4_n  = 1'b0;
        if1.pwm_enable = 1'b0; if1.pwm_update = 1'b0; if1.pwm_ratio = '0; if1.pwm_direction = 1'b0;
        if4.pwm_enable = 1'b0; if4.pwm_update = 1'b0; if4.pwm_ratio = '0; if4.pwm_direction = 1'b0;

        @(negedge clock);
        check("rst_done1", int'(if1.pwm_done), 0);
        check("rst_out1", int'(out1), 0);
        check("rst_dir1", int'(dir1), 0);
        check("rst_ratio1", int'(ar1), 0);
        check("rst_done4", int'(if4.pwm_done), 0);
        check("rst_out4", int'(out4), 0);
        reset_n = 1'b1;
        rst4_n  = 1'b1;
        repeat (2) @(negedge clock);

        // Enable with ratio 64, first load at the first boundary.
        c0 = cyc;
        if1.pwm_enable = 1'b1; if1.pwm_update = 1'b1; if1.pwm_ratio = 8'd64; if1.pwm_direction = 1'b0;
        b = c0 + 257;
        push1(b, 64, 0);
        to_cyc(b);
        push1(b + 256, 64, 0);
        count_high(256, 1'b0, h1);
        check("t1_high64", h1, 64);
        check("t1_dir", int'(dir1), 0);
        b += 256;

        // Ratio 0 then 255.
        if1.pwm_ratio = 8'd0;
        push1(b + 256, 0, 0);
        count_high(256, 1'b0, h1);
        check("t2_prev64", h1, 64);
        b += 256;
        if1.pwm_ratio = 8'd255;
        push1(b + 256, 255, 0);
        count_high(256, 1'b0, h1);
        check("t2_ratio0", h1, 0);
        b += 256;
        if1.pwm_ratio = 8'd64;
        push1(b + 256, 64, 0);
        count_high(256, 1'b0, h1);
        check("t2_ratio255", h1, 255);
        b += 256;

        // Mid-period ratio change has no effect until the next boundary.
        count_high(100, 1'b0, h1);
        if1.pwm_ratio = 8'd200;
        push1(b + 256, 200, 0);
        count_high(156, 1'b0, h2);
        check("t3_glitchfree64", h1 + h2, 64);
        b += 256;
        if1.pwm_ratio = 8'd128;
        push1(b + 256, 128, 0);
        count_high(256, 1'b0, h1);
        check("t3_ratio200", h1, 200);
        b += 256;

        // Direction reversal with dead time.
        if1.pwm_direction = 1'b1;
        count_high(256, 1'b0, h1);
        check("t4_pre128", h1, 128);
        b += 256;
        check("t4_dt_active", int'(ar1), 0);
        push1(b + 512, 128, 1);
        count_high(256, 1'b0, h1);
        check("t4_dir_held", int'(dir1), 0);
        count_high(256, 1'b0, h2);
        check("t4_dead_low", h1 + h2, 0);
        b += 512;
        check("t4_dir_flip", int'(dir1), 1);
        if1.pwm_update = 1'b0;
        count_high(256, 1'b0, h1);
        check("t4_post128", h1, 128);
        b += 256;
        check("t4_hold_noupdate", int'(ar1), 128);

        // Disable mid-period, then restart.
        to_cyc(b + 50);
        check("t5_pre_drop_out", int'(out1), 1);
        if1.pwm_enable = 1'b0;
        @(negedge clock);
        check("t5_drop_out", int'(out1), 0);
        check("t5_drop_ratio", int'(ar1), 0);
        check("t5_drop_dir", int'(dir1), 1);
        count_high(20, 1'b0, h1);
        check("t5_idle_low", h1, 0);
        c1 = cyc;
        if1.pwm_enable = 1'b1; if1.pwm_update = 1'b1; if1.pwm_ratio = 8'd30; if1.pwm_direction = 1'b1;
        b = c1 + 257;
        push1(b, 30, 1);
        to_cyc(b);
        push1(b + 256, 30, 1);
        count_high(256, 1'b0, h1);
        check("t5_restart30", h1, 30);
        b += 256;

        // Disable on the cycle before a boundary: no load, no pulse.
        to_cyc(b + 255);
        if1.pwm_enable = 1'b0;
        @(negedge clock);
        check("t5_bdisable_ratio", int'(ar1), 0);
        check("t5_bdisable_out", int'(out1), 0);
        repeat (300) @(negedge clock);

        // PRESCALE=4 instance, then async reset mid-period.
        c2 = cyc;
        if4.pwm_enable = 1'b1; if4.pwm_update = 1'b1; if4.pwm_ratio = 8'd10; if4.pwm_direction = 1'b0;
        b = c2 + 1025;
        push4(b, 10, 0);
        to_cyc(b);
        push4(b + 1024, 10, 0);
        count_high(1024, 1'b1, h1);
        check("t6_high40", h1, 40);
        b += 1024;
        to_cyc(b + 20);
        check("t6_pre_rst_out", int'(out4), 1);
        check("t6_pre_rst_ratio", int'(ar4), 10);
        #2 rst4_n = 1'b0;
        #1;
        check("t6_rst_out", int'(out4), 0);
        check("t6_rst_ratio", int'(ar4), 0);
        check("t6_rst_dir", int'(dir4), 0);
        check("t6_rst_done", int'(if4.pwm_done), 0);
        @(negedge clock);
        rst4_n = 1'b1;
        repeat (5) @(negedge clock);

        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
